// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 data-memory controller.
//   - icode constants for every instruction that touches data memory
//   - dmem_state_t : controller FSM state encoding
//   - dmem_op_t    : decoded memory operation kind
//   - decode_op()  : icode -> memory operation
package y86_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } dmem_op_t;

    function automatic dmem_op_t decode_op(input logic [3:0] icode);
        dmem_op_t op;
        case (icode)
            IMRMOVQ, IRET, IPOPQ:   op = OP_READ;
            IRMMOVQ, ICALL, IPUSHQ: op = OP_WRITE;
            default:                op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/y86_byte_ram.sv
// Byte-addressable storage array with a single word-wide, byte-granular port.
// Little-endian: byte addr+i maps to bits [8i+7:8i] of the word.
// The caller guarantees addr+WORD_BYTES-1 < MEM_BYTES; there is no bounds logic
// and no reset of the contents.
// Ports:
//   clk    in  1             write clock (rising edge)
//   we     in  1             write enable, commits wdata at addr on the clock edge
//   addr   in  AW            starting byte address
//   wdata  in  8*WORD_BYTES  write data
//   rdata  out 8*WORD_BYTES  combinational read data at addr
module y86_byte_ram #(
    parameter int MEM_BYTES  = 512,
    parameter int WORD_BYTES = 8,
    parameter int AW         = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           addr,
    input  logic [8*WORD_BYTES-1:0] wdata,
    output logic [8*WORD_BYTES-1:0] rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                mem[addr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_rd
        assign rdata[8*g +: 8] = mem[addr + AW'(g)];
    end

endmodule

// File: rtl/y86_dmem_ctrl.sv
// Y86 data-memory controller for the multi-cycle memory stage.
// Decodes icode into a read or write, checks bounds on the full-width address,
// and returns valM / dmem_error over a valid/ready handshake after LATENCY cycles.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- when defined, an address that is
// not a multiple of WORD_BYTES also faults.
// Ports:
//   clk         in  1   clock, rising edge
//   rst_n       in  1   asynchronous active-low reset
//   req_valid   in  1   request present
//   req_ready   out 1   high only in IDLE
//   icode       in  4   Y86 icode of the memory-stage instruction
//   valA        in  DW  store data for 4/A, address for 9/B
//   valE        in  DW  address for 4/5/8/A
//   valP        in  DW  store data for call
//   resp_valid  out 1   response present (RESP state)
//   resp_ready  in  1   stage accepts the response
//   valM        out DW  read data, holds until the next response
//   dmem_error  out 1   access fault, qualified by resp_valid
//
// state     | meaning
// ----------+---------------------------------------------------------
// DMEM_IDLE | ready for a request; latches icode/address/data on accept
// DMEM_BUSY | latency countdown; cnt reaching 1 moves to RESP
// DMEM_RESP | response presented; held until resp_ready is sampled high
module y86_dmem_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_BYTES  = 512,
    parameter int WORD_BYTES = 8,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              icode,
    input  logic [8*WORD_BYTES-1:0] valA,
    input  logic [8*WORD_BYTES-1:0] valE,
    input  logic [8*WORD_BYTES-1:0] valP,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [8*WORD_BYTES-1:0] valM,
    output logic                    dmem_error
);

    localparam int DW = 8*WORD_BYTES;
    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [DW-1:0] MAX_ADDR = DW'(MEM_BYTES - WORD_BYTES);

    dmem_state_t   state_q;
    logic [CW-1:0] cnt_q;
    dmem_op_t      op_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] valm_q;
    logic          err_q;

    dmem_op_t      in_op;
    logic [DW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    dmem_op_t      cur_op;
    logic [DW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic          addr_fault;
    logic          fault;
    logic          accept;
    logic          enter_resp;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    assign in_op    = decode_op(icode);
    assign in_addr  = (icode == IRET || icode == IPOPQ) ? valA : valE;
    assign in_wdata = (icode == ICALL) ? valP : valA;

    // With LATENCY=1 the commit edge is the accept edge itself, so the commit
    // must see the live request; otherwise it sees the latched copy.
    assign cur_op    = (state_q == DMEM_IDLE) ? in_op    : op_q;
    assign cur_addr  = (state_q == DMEM_IDLE) ? in_addr  : addr_q;
    assign cur_wdata = (state_q == DMEM_IDLE) ? in_wdata : wdata_q;

    always_comb begin
        addr_fault = (cur_addr > MAX_ADDR);
`ifdef MEM_ALIGN_CHECK_EN
        if ((cur_addr % DW'(WORD_BYTES)) != '0) begin
            addr_fault = 1'b1;
        end
`endif
    end

    assign fault = (cur_op != OP_NONE) && addr_fault;

    assign accept     = (state_q == DMEM_IDLE) && req_valid;
    assign enter_resp = (LATENCY == 1) ? accept
                                       : ((state_q == DMEM_BUSY) && (cnt_q == CW'(1)));

    // A faulting or no-op access never reaches the array.
    assign ram_we = enter_resp && (cur_op == OP_WRITE) && !fault;

    y86_byte_ram #(
        .MEM_BYTES  (MEM_BYTES),
        .WORD_BYTES (WORD_BYTES),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur_addr[AW-1:0]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            valm_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                DMEM_IDLE: begin
                    if (req_valid) begin
                        op_q    <= in_op;
                        addr_q  <= in_addr;
                        wdata_q <= in_wdata;
                        if (LATENCY == 1) begin
                            state_q <= DMEM_RESP;
                        end else begin
                            state_q <= DMEM_BUSY;
                            cnt_q   <= CW'(LATENCY - 1);
                        end
                    end
                end
                DMEM_BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= DMEM_RESP;
                    end
                end
                DMEM_RESP: begin
                    if (resp_ready) begin
                        state_q <= DMEM_IDLE;
                    end
                end
                default: state_q <= DMEM_IDLE;
            endcase

            // Successful reads load valM, no-ops clear it; writes and faults
            // leave the previous response data in place.
            if (enter_resp) begin
                err_q <= fault;
                case (cur_op)
                    OP_READ: if (!fault) valm_q <= ram_rdata;
                    OP_NONE: valm_q <= '0;
                    default: ;
                endcase
            end
        end
    end

    assign req_ready  = (state_q == DMEM_IDLE);
    assign resp_valid = (state_q == DMEM_RESP);
    assign valM       = valm_q;
    assign dmem_error = err_q;

endmodule

// File: tb/tb_y86_dmem_ctrl.sv
module tb_y86_dmem_ctrl;

    localparam int MEM_BYTES  = 512;
    localparam int WORD_BYTES = 8;
    localparam int LATENCY    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] valM;
    logic        dmem_error;

    int n_cmp = 0;
    int n_mis = 0;

    byte unsigned mem_m [MEM_BYTES];
    logic [63:0]  m_valm;

    y86_dmem_ctrl #(
        .MEM_BYTES  (MEM_BYTES),
        .WORD_BYTES (WORD_BYTES),
        .LATENCY    (LATENCY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .icode      (icode),
        .valA       (valA),
        .valE       (valE),
        .valP       (valP),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .valM       (valM),
        .dmem_error (dmem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Reference: plain byte array plus the decode/bounds rules.
    task automatic do_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input int hold);
        logic [63:0] addr, wd, rv;
        bit rd, wr, flt;
        int edges;
        rd   = ic inside {4'h5, 4'h9, 4'hB};
        wr   = ic inside {4'h4, 4'h8, 4'hA};
        addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
        wd   = (ic == 4'h8) ? p : a;
        flt  = (rd || wr) && (addr > 64'(MEM_BYTES - WORD_BYTES));
`ifdef MEM_ALIGN_CHECK_EN
        if ((rd || wr) && (addr % WORD_BYTES) != 0) flt = 1'b1;
`endif
        if (!rd && !wr) begin
            m_valm = '0;
        end else if (rd && !flt) begin
            rv = '0;
            for (int i = 0; i < WORD_BYTES; i++)
                rv |= 64'(mem_m[int'(addr) + i]) << (8*i);
            m_valm = rv;
        end
        if (wr && !flt) begin
            for (int i = 0; i < WORD_BYTES; i++)
                mem_m[int'(addr) + i] = wd[8*i +: 8];
        end

        chk("req_ready_idle", {63'b0, req_ready}, 64'd1);
        icode = ic; valA = a; valE = e; valP = p; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        icode = 4'($urandom); valA = {$urandom, $urandom};
        valE = {$urandom, $urandom}; valP = {$urandom, $urandom};
        edges = 1;
        while (!resp_valid && edges < 16) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", 64'(edges), 64'(LATENCY));
        chk("valM", valM, m_valm);
        chk("dmem_error", {63'b0, dmem_error}, {63'b0, flt});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_resp_valid", {63'b0, resp_valid}, 64'd1);
            chk("hold_valM", valM, m_valm);
            chk("hold_req_ready", {63'b0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("release_resp_valid", {63'b0, resp_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] e, a;
        logic [3:0]  ic;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        icode = '0; valA = '0; valE = '0; valP = '0;
        m_valm = '0;
        for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;

        #1;
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_dmem_error", {63'b0, dmem_error}, 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Array contents are not reset, so clear them through the port.
        for (int i = 0; i <= MEM_BYTES - WORD_BYTES; i += WORD_BYTES)
            do_op(4'h4, 64'd0, 64'(i), 64'd0, 0);

        do_op(4'h4, 64'h1122334455667788, 64'h10, 64'd0, 0);
        do_op(4'h5, 64'd0, 64'h10, 64'd0, 0);
        chk("wr_rd_const", valM, 64'h1122334455667788);
        do_op(4'h5, 64'd0, 64'h11, 64'd0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("align_err_const", {63'b0, dmem_error}, 64'd1);
        chk("align_valM_const", valM, 64'h1122334455667788);
`else
        chk("unaligned_const", valM, 64'h0011223344556677);
`endif

        do_op(4'h4, 64'hCAFEF00DDEADBEEF, 64'd504, 64'd0, 0);
        do_op(4'h4, 64'h5555555555555555, 64'd505, 64'd0, 0);
        chk("oob_505_err", {63'b0, dmem_error}, 64'd1);
        do_op(4'h5, 64'd0, 64'd504, 64'd0, 0);
        chk("bound_504_const", valM, 64'hCAFEF00DDEADBEEF);
        do_op(4'h5, 64'd0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 0);
        chk("oob_wrap_err", {63'b0, dmem_error}, 64'd1);

        do_op(4'h8, 64'd0, 64'h100, 64'h2A, 0);
        do_op(4'h9, 64'h100, 64'd0, 64'd0, 0);
        chk("ret_const", valM, 64'h2A);

        do_op(4'h5, 64'd0, 64'h10, 64'd0, 3);
        do_op(4'h0, 64'd0, 64'h10, 64'd0, 1);
        do_op(4'h7, 64'd0, 64'h10, 64'd0, 0);

        // Reset while BUSY on a write to 0x20: the write must not land.
        do_op(4'h4, 64'h0123456789ABCDEF, 64'h20, 64'd0, 0);
        icode = 4'h4; valE = 64'h20; valA = 64'hFFFF0000FFFF0000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("busy_req_ready", {63'b0, req_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("abort_req_ready", {63'b0, req_ready}, 64'd1);
        chk("abort_valM", valM, 64'd0);
        m_valm = '0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(4'h5, 64'd0, 64'h20, 64'd0, 0);
        chk("abort_prior_const", valM, 64'h0123456789ABCDEF);

        for (int n = 0; n < 200; n++) begin
            ic = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) e = {32'hFFFFFFFF, $urandom};
            else if ($urandom_range(0, 1) == 0) e = 64'($urandom_range(0, 65) * 8);
            else e = 64'($urandom_range(0, 520));
            if (ic == 4'h9 || ic == 4'hB) begin
                a = e; e = {$urandom, $urandom};
            end else begin
                a = {$urandom, $urandom};
            end
            do_op(ic, a, e, {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
